// File: rtl/lcd_speed_writer.sv
// Feeds a 16x2 HD44780-style LCD driver: init, "SPEED:" header, then one
// digit cell rewritten each time the incoming ASCII speed character changes.
module lcd_speed_writer #(
  parameter logic [7:0] DIGIT_ADDR = 8'h87,
  parameter logic [7:0] HDR_ADDR   = 8'h80
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] ascii_speed,
  input  logic       lcd_ready,
  output logic       lcd_valid,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       busy,
  output logic [7:0] shown_char,
  output logic [7:0] update_count
);

  typedef enum logic [2:0] {
    INIT,
    HDR,
    UPD_ADDR,
    UPD_CHAR,
    IDLE
  } state_t;

  state_t     state;
  state_t     nxt_state;
  logic [2:0] idx;
  logic [2:0] nxt_idx;
  logic [7:0] latched;
  logic [8:0] nxt_byte;

  // {rs, data} for a given position in the byte sequence.
  function automatic logic [8:0] byte_for(input state_t s, input logic [2:0] i,
                                          input logic [7:0] ch);
    logic [8:0] b;
    b = 9'h000;
    case (s)
      INIT: begin
        case (i)
          3'd0:    b = {1'b0, 8'h38};
          3'd1:    b = {1'b0, 8'h0C};
          3'd2:    b = {1'b0, 8'h01};
          default: b = {1'b0, 8'h06};
        endcase
      end
      HDR: begin
        case (i)
          3'd0:    b = {1'b0, HDR_ADDR};
          3'd1:    b = {1'b1, 8'h53};
          3'd2:    b = {1'b1, 8'h50};
          3'd3:    b = {1'b1, 8'h45};
          3'd4:    b = {1'b1, 8'h45};
          3'd5:    b = {1'b1, 8'h44};
          default: b = {1'b1, 8'h3A};
        endcase
      end
      UPD_ADDR: b = {1'b0, DIGIT_ADDR};
      UPD_CHAR: b = {1'b1, ch};
      default:  b = 9'h000;
    endcase
    return b;
  endfunction

  // Where the sequence goes once the current byte has been accepted.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch inferred.
    nxt_state = state;
    nxt_idx   = idx + 3'd1;
    case (state)
      INIT: begin
        if (idx == 3'd3) begin
          nxt_state = HDR;
          nxt_idx   = 3'd0;
        end
      end
      HDR: begin
        if (idx == 3'd6) begin
          nxt_state = UPD_ADDR;
          nxt_idx   = 3'd0;
        end
      end
      UPD_ADDR: begin
        nxt_state = UPD_CHAR;
        nxt_idx   = 3'd0;
      end
      UPD_CHAR: begin
        nxt_state = IDLE;
        nxt_idx   = 3'd0;
      end
      default: nxt_idx = 3'd0;
    endcase
  end

  assign nxt_byte = byte_for(nxt_state, nxt_idx, latched);

  // NOTE: non-blocking assignments for all state so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= INIT;
      idx          <= 3'd0;
      lcd_valid    <= 1'b0;
      lcd_data     <= 8'h00;
      lcd_rs       <= 1'b0;
      busy         <= 1'b1;
      shown_char   <= 8'h20;
      update_count <= 8'h00;
      latched      <= 8'h20;
    end else if (state == IDLE) begin
      if (ascii_speed != shown_char) begin
        latched <= ascii_speed;
        state   <= UPD_ADDR;
        idx     <= 3'd0;
        busy    <= 1'b1;
      end
    end else if (!lcd_valid) begin
      // First byte of a burst: after reset or after an IDLE-detected change.
      {lcd_rs, lcd_data} <= byte_for(state, idx, latched);
      lcd_valid          <= 1'b1;
    end else if (lcd_ready) begin
      state <= nxt_state;
      idx   <= nxt_idx;
      if (state == HDR && nxt_state == UPD_ADDR) begin
        latched <= ascii_speed;
      end
      if (state == UPD_CHAR) begin
        shown_char   <= latched;
        update_count <= update_count + 8'd1;
        lcd_valid    <= 1'b0;
        busy         <= 1'b0;
      end else begin
        {lcd_rs, lcd_data} <= nxt_byte;
      end
    end
  end

endmodule

// File: tb/tb_lcd_speed_writer.sv
// Randomised bench for lcd_speed_writer: a byte-queue reference model is
// compared against the DUT on every falling edge, plus literal sequence checks.
module tb_lcd_speed_writer;

  logic       clk;
  logic       resetn;
  logic [7:0] ascii_speed;
  logic       lcd_ready;
  logic       lcd_valid;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       busy;
  logic [7:0] shown_char;
  logic [7:0] update_count;

  lcd_speed_writer dut (
    .clk          (clk),
    .resetn       (resetn),
    .ascii_speed  (ascii_speed),
    .lcd_ready    (lcd_ready),
    .lcd_valid    (lcd_valid),
    .lcd_data     (lcd_data),
    .lcd_rs       (lcd_rs),
    .busy         (busy),
    .shown_char   (shown_char),
    .update_count (update_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the bytes still owed to the LCD, in order.
  // kind 1 = last header byte (digit is latched when it goes), kind 2 = digit char.
  typedef struct packed {
    logic       rs;
    logic [7:0] data;
    logic [1:0] kind;
  } item_t;

  item_t      q[$];
  item_t      head;
  logic       m_valid;
  logic [7:0] m_shown;
  logic [7:0] m_count;

  task automatic model_reset();
    logic [7:0] cmds [5];
    logic [7:0] hdr  [6];
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};
    hdr  = '{8'h53, 8'h50, 8'h45, 8'h45, 8'h44, 8'h3A};
    q.delete();
    foreach (cmds[i]) q.push_back('{1'b0, cmds[i], 2'd0});
    foreach (hdr[i]) q.push_back('{1'b1, hdr[i], (i == 5) ? 2'd1 : 2'd0});
    m_valid = 1'b0;
    m_shown = 8'h20;
    m_count = 8'h00;
  endtask

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      model_reset();
    end else if (q.size() == 0) begin
      if (ascii_speed != m_shown) begin
        q.push_back('{1'b0, 8'h87, 2'd0});
        q.push_back('{1'b1, ascii_speed, 2'd2});
      end
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (lcd_ready) begin
      head = q.pop_front();
      if (head.kind == 2'd1) begin
        q.push_back('{1'b0, 8'h87, 2'd0});
        q.push_back('{1'b1, ascii_speed, 2'd2});
      end
      if (head.kind == 2'd2) begin
        m_shown = head.data;
        m_count = m_count + 8'd1;
      end
      if (q.size() == 0) m_valid = 1'b0;
    end
  end

  // Transfers seen on the DUT interface and count of cycles with lcd_valid high.
  logic [8:0] log_q[$];
  int         vcnt;

  always @(negedge clk) begin
    if (resetn) begin
      check("lcd_valid", lcd_valid, m_valid);
      if (m_valid) begin
        check("lcd_data", lcd_data, q[0].data);
        check("lcd_rs", lcd_rs, q[0].rs);
      end
      check("busy", busy, q.size() != 0);
      check("shown_char", shown_char, m_shown);
      check("update_count", update_count, m_count);
      if (lcd_valid) vcnt++;
      if (lcd_valid && lcd_ready) log_q.push_back({lcd_rs, lcd_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic run_until_idle(input int limit);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (q.size() != 0 && n < limit);
    check("idle_within_budget", q.size() == 0, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, lcd_valid, 1'b0);
    check({tag, "_data"}, lcd_data, 8'h00);
    check({tag, "_rs"}, lcd_rs, 1'b0);
    check({tag, "_busy"}, busy, 1'b1);
    check({tag, "_shown"}, shown_char, 8'h20);
    check({tag, "_count"}, update_count, 8'h00);
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    log_q.delete();
    vcnt   = 0;
    resetn = 1'b1;
  endtask

  // Literal boot sequence with ascii_speed = 8'h30.
  task automatic check_boot(input string tag);
    logic [8:0] exp [13];
    exp = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080, 9'h153, 9'h150,
            9'h145, 9'h145, 9'h144, 9'h13A, 9'h087, 9'h130};
    check({tag, "_len"}, log_q.size(), 13);
    foreach (exp[i]) begin
      if (i < log_q.size()) check({tag, "_byte"}, log_q[i], exp[i]);
    end
  endtask

  task automatic check_log(input string tag, input logic [8:0] exp [$]);
    check({tag, "_len"}, log_q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < log_q.size()) check({tag, "_byte"}, log_q[i], exp[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn      = 1'b0;
    ascii_speed = 8'h30;
    lcd_ready   = 1'b1;
    #1;

    // Power-up with the driver always ready.
    apply_reset();
    run_until_idle(40);
    check_boot("boot");
    check("boot_valid_cycles", vcnt, 13);
    check("boot_shown", shown_char, 8'h30);
    check("boot_count", update_count, 8'd1);
    check("boot_busy", busy, 1'b0);

    // Backpressure: ready only one cycle in three.
    apply_reset();
    n = 0;
    do begin
      lcd_ready = (n % 3 == 2);
      tick();
      n++;
    end while (q.size() != 0 && n < 120);
    check("bp_idle_within_budget", q.size() == 0, 1'b1);
    lcd_ready = 1'b1;
    check_boot("bp");

    // Single change in IDLE, then hold.
    log_q.delete();
    ascii_speed = 8'h33;
    run_until_idle(20);
    repeat (8) tick();
    check_log("upd33", '{9'h087, 9'h133});
    check("upd33_count", update_count, 8'd2);

    // Input changes while the digit char is stalled.
    log_q.delete();
    ascii_speed = 8'h31;
    n = 0;
    do begin
      tick();
      n++;
    end while (!(q.size() == 1 && m_valid) && n < 20);
    check("stall_reached", q.size() == 1 && m_valid, 1'b1);
    lcd_ready = 1'b0;
    tick();
    ascii_speed = 8'h34;
    tick();
    ascii_speed = 8'h35;
    tick();
    lcd_ready = 1'b1;
    run_until_idle(20);
    run_until_idle(20);
    check_log("drop34", '{9'h087, 9'h131, 9'h087, 9'h135});
    check("drop34_shown", shown_char, 8'h35);
    check("drop34_count", update_count, 8'd4);

    // Reset pulsed while a header byte is being offered.
    ascii_speed = 8'h30;
    apply_reset();
    repeat (7) tick();
    check("midhdr_valid_before", lcd_valid, 1'b1);
    resetn = 1'b0;
    #1;
    check_reset_values("midhdr");
    tick();
    log_q.delete();
    resetn = 1'b1;
    run_until_idle(40);
    check_boot("restart");

    // Random input changes and random backpressure.
    for (int i = 0; i < 600; i++) begin
      tick();
      lcd_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 4) == 0) ascii_speed = 8'($urandom);
        else ascii_speed = 8'h30 + 8'($urandom_range(0, 9));
      end
    end
    lcd_ready = 1'b1;
    run_until_idle(40);
    tick();
    run_until_idle(40);
    check("rand_settled_shown", shown_char, ascii_speed);

    // 256 digit writes in total after reset: counter wraps to zero.
    ascii_speed = 8'h30;
    apply_reset();
    run_until_idle(40);
    for (int k = 1; k < 256; k++) begin
      ascii_speed = (k % 2 == 1) ? 8'h31 : 8'h30;
      run_until_idle(20);
    end
    check("wrap_count", update_count, 8'd0);
    check("wrap_shown", shown_char, 8'h31);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
